// File: rtl/rv_instr_encoder_loader.sv
// rv_instr_encoder_loader
// Turns symbolic RV32I instruction requests into 32-bit machine words,
// buffers them in a small FIFO and streams them into instruction memory
// at consecutive word addresses through a write/ack handshake.
//
// Ports:
//   clk, rst_n            clock (rising edge) and asynchronous active-low reset
//   start, finish         session control pulses
//   in_valid / in_ready   request handshake
//   in_class              0=R 1=I-ALU 2=LW 3=SW 4=BRANCH 5=JAL 6=JALR 7=illegal
//   in_rd/rs1/rs2         register indices
//   in_funct3/in_funct7   function fields
//   in_imm                signed byte-offset immediate
//   mem_we/addr/wdata     memory write request, held until mem_ack
//   mem_ack               write completes when mem_we && mem_ack
//   busy, done, err       status (done is a one-cycle pulse, err is sticky)
//   word_count            words written in the current session
module rv_instr_encoder_loader #(
   parameter int                ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
   parameter int                DEPTH     = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              finish,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        in_class,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_rs1,
   input  logic [4:0]        in_rs2,
   input  logic [2:0]        in_funct3,
   input  logic [6:0]        in_funct7,
   input  logic [31:0]       in_imm,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic              mem_ack,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [15:0]       word_count
);

   localparam int              PTR_W    = $clog2(DEPTH);
   localparam logic [PTR_W:0]  FULL_OCC = (PTR_W+1)'(DEPTH);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [15:0]       word_count_q, word_count_d;
   logic              err_q, err_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]    occ_q, occ_d;
   logic [31:0]       fifo_mem_q [DEPTH];

   logic [31:0] enc_word;
   logic        fifo_empty, fifo_full;
   logic        accept, push, pop;

   // Immediate bits above bit 20 never appear in any encoding.
   logic [10:0] unused_imm_hi;
   assign unused_imm_hi = in_imm[31:21];

   assign fifo_empty = (occ_q == '0);
   assign fifo_full  = (occ_q == FULL_OCC);

   // Ready looks only at registered occupancy, so a full FIFO stalls input
   // even in a cycle where the head is being popped.
   assign in_ready   = (state_q == ST_RUN) && !fifo_full;
   assign mem_we     = !fifo_empty && ((state_q == ST_RUN) || (state_q == ST_DRAIN));
   assign mem_wdata  = mem_we ? fifo_mem_q[rd_ptr_q] : 32'd0;
   assign mem_addr   = addr_q;
   assign busy       = (state_q != ST_IDLE);
   assign done       = (state_q == ST_DONE);
   assign err        = err_q;
   assign word_count = word_count_q;

   // Illegal requests complete the handshake but never enter the FIFO.
   assign accept = in_valid && in_ready;
   assign push   = accept && (in_class != 3'd7);
   assign pop    = mem_we && mem_ack;

   // Combinational RV32I encoder; immediates are scattered into the fixed
   // S/B/J field positions and any unused bits are simply dropped.
   always_comb begin
      enc_word = 32'd0;
      case (in_class)
         3'd0: enc_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, 7'b0110011};
         3'd1: enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0010011};
         3'd2: enc_word = {in_imm[11:0], in_rs1, 3'b010, in_rd, 7'b0000011};
         3'd3: enc_word = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], 7'b0100011};
         3'd4: enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                           in_imm[4:1], in_imm[11], 7'b1100011};
         3'd5: enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                           in_rd, 7'b1101111};
         3'd6: enc_word = {in_imm[11:0], in_rs1, 3'b000, in_rd, 7'b1100111};
         default: enc_word = 32'd0;
      endcase
   end

   // Session state, write address, counters and FIFO pointers.
   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      word_count_d = word_count_q;
      err_d        = err_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      occ_d        = occ_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d      = ST_RUN;
               addr_d       = BASE_ADDR;
               word_count_d = 16'd0;
               err_d        = 1'b0;
            end
         end
         ST_RUN: begin
            if (finish) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            // Nothing can be pushed here, so the FIFO is drained once it is
            // empty or its last word is acknowledged this cycle.
            if (fifo_empty || ((occ_q == (PTR_W+1)'(1)) && pop)) state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (accept && (in_class == 3'd7)) err_d = 1'b1;

      if (pop) begin
         addr_d       = addr_q + ADDR_W'(4);
         word_count_d = word_count_q + 16'd1;
         rd_ptr_d     = rd_ptr_q + PTR_W'(1);
      end
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);

      case ({push, pop})
         2'b10:   occ_d = occ_q + (PTR_W+1)'(1);
         2'b01:   occ_d = occ_q - (PTR_W+1)'(1);
         default: occ_d = occ_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         addr_q       <= BASE_ADDR;
         word_count_q <= 16'd0;
         err_q        <= 1'b0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         occ_q        <= '0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         word_count_q <= word_count_d;
         err_q        <= err_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         occ_q        <= occ_d;
      end
   end

   // FIFO storage needs no reset: occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (push) fifo_mem_q[wr_ptr_q] <= enc_word;
   end

endmodule

// File: doc/rv_instr_encoder_loader.md
Name: rv_instr_encoder_loader

Overview:
- Inverse of the opcode decode path: takes symbolic instruction requests (class, register indices, funct fields, immediate) and encodes them into 32-bit RV32I words.
- Buffers the encoded words in a small FIFO and writes them sequentially into instruction memory through a write/ack handshake.
- Used to load programs into IMEM for the RISC-V core, and by bring-up logic, without an external assembler.

Parameters:
- ADDR_W, 32, instruction memory byte-address width.
- BASE_ADDR, 0, first write address after start.
- DEPTH, 4, FIFO depth in words; power of 2, at least 2.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  pulse that begins a load session.
- finish  in  1  pulse that ends input; buffered words drain, then done.
- in_valid  in  1  instruction request valid.
- in_ready  out  1  request accepted when in_valid && in_ready.
- in_class  in  3  0=R, 1=I-ALU, 2=LW, 3=SW, 4=BRANCH, 5=JAL, 6=JALR, 7=illegal.
- in_rd, in_rs1, in_rs2  in  5 each  register indices.
- in_funct3  in  3; in_funct7  in  7  function fields.
- in_imm  in  32  signed immediate, byte offset.
- mem_we  out  1  write request.
- mem_addr  out  ADDR_W  byte address.
- mem_wdata  out  32  encoded instruction.
- mem_ack  in  1  write completes on a cycle where mem_we && mem_ack.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse at end of session.
- err  out  1  sticky; an illegal class was received this session.
- word_count  out  16  words written this session.

Behaviour:
- Reset (asynchronous, rst_n low): state=IDLE, FIFO empty, mem_addr=BASE_ADDR, word_count=0, err=0, and in_ready, mem_we, mem_wdata, busy, done all 0.
- States and transitions:
  - IDLE: start -> RUN. On that transition mem_addr=BASE_ADDR, word_count=0, err=0. finish is ignored in IDLE. If start and finish arrive together, start wins.
  - RUN: finish -> DRAIN. start is ignored.
  - DRAIN: when the FIFO is empty and no write is pending -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
- in_ready = (state==RUN) && FIFO not full. Ready is not combinationally dependent on pop; a full FIFO stalls input even on a pop cycle.
- On accept, the word is encoded combinationally and pushed at the clock edge. Latency from accept at cycle N to mem_we: earliest N+1.
- Class 7: sets err, nothing is pushed, and the handshake still completes.
- Encoding (opcode in [6:0], rd [11:7], f3 [14:12], rs1 [19:15], rs2 [24:20]):
  - R: funct7 | rs2 | rs1 | funct3 | rd | 0110011.
  - I-ALU: imm[11:0] | rs1 | funct3 | rd | 0010011.
  - LW: imm[11:0] | rs1 | 010 | rd | 0000011. funct3 input ignored.
  - SW: imm[11:5] | rs2 | rs1 | 010 | imm[4:0] | 0100011.
  - BRANCH: imm[12] | imm[10:5] | rs2 | rs1 | funct3 | imm[4:1] | imm[11] | 1100011. imm[0] ignored.
  - JAL: imm[20] | imm[10:1] | imm[11] | imm[19:12] | rd | 1101111. imm[0] ignored.
  - JALR: imm[11:0] | rs1 | 000 | rd | 1100111.
  - Unused imm bits are truncated. No range check.
- Write side:
  - mem_we = FIFO not empty && state in {RUN, DRAIN}.
  - mem_wdata = FIFO head; mem_addr = current address.
  - Both are held stable while mem_we && !mem_ack.
  - On mem_we && mem_ack: pop, mem_addr += 4 (wraps modulo 2^ADDR_W), word_count += 1 (wraps at 16 bits).
- Push and pop in the same cycle (FIFO not full): occupancy unchanged, order preserved.
- done is never asserted together with mem_we.
- Reset mid-session discards FIFO contents and any pending write. No partial-write recovery.

Test Plan:
- Reset, then start; push class0 rd=3 rs1=1 rs2=2 f3=0 f7=0 (add x3,x1,x2); mem_ack=1 -> one write of 0x002081B3 at addr 0x0; word_count=1.
- Push class1 rd=5 rs1=0 f3=0 imm=-1 (addi x5,x0,-1), then class3 rs1=1 rs2=2 imm=8 (sw x2,8(x1)) -> 0xFFF00293 at 0x0, then 0x0020A423 at 0x4, in order.
- Push class4 rs1=1 rs2=2 f3=0 imm=-4 (beq) and class5 rd=1 imm=8 (jal x1,+8) -> 0xFE208EE3 and 0x008000EF at consecutive addresses.
- Hold mem_ack=0 and push DEPTH words -> in_ready drops after 4 accepts; mem_wdata and mem_addr stay stable. Release ack -> all 4 words written in order, in_ready returns.
- Push class7, then a valid add, then pulse finish -> err=1, exactly one word written, done pulses one cycle after the last ack, busy=0 afterwards; a new start clears err and word_count.
- Deassert rst_n mid-drain with 2 words buffered -> all outputs 0 immediately, mem_addr=BASE_ADDR; after release, a new session writes from 0x0.
